// File: rtl/snake_pic_gen.sv
// Snake game pixel generator: holds the game state, advances it during vertical
// blanking and returns a registered RGB565 colour for each requested pixel.
module snake_pic_gen #(
  parameter int          MAX_LEN     = 16,
  parameter int          STEP_FRAMES = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [15:0] pix_data,
  output logic        game_over,
  output logic [7:0]  score
);

  typedef enum logic {ST_RUN, ST_OVER} state_e;
  // Encoding chosen so the reverse direction is the value with bit 0 flipped.
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d, pend_q, pend_d, key_dir;
  logic [5:0]  seg_x_q [MAX_LEN];
  logic [5:0]  seg_x_d [MAX_LEN];
  logic [4:0]  seg_y_q [MAX_LEN];
  logic [4:0]  seg_y_d [MAX_LEN];
  logic [5:0]  len_q, len_d;
  logic [5:0]  food_x_q, food_x_d;
  logic [4:0]  food_y_q, food_y_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  score_q, score_d;
  logic        move_q, move_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] pix_q, pix_d;

  logic        key_any, active, is_head, is_body, is_food;
  logic        wall, eat, self_hit;
  logic [5:0]  cx, nh_x, fx, hit_lim;
  logic [4:0]  cy, nh_y, fy;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    food_x_d    = food_x_q;
    food_y_d    = food_y_q;
    frame_cnt_d = frame_cnt_q;
    score_d     = score_q;
    move_d      = move_q;
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    key_any = key_up | key_down | key_left | key_right;
    key_dir = DIR_RIGHT;
    if (key_left) key_dir = DIR_LEFT;
    if (key_down) key_dir = DIR_DOWN;
    if (key_up)   key_dir = DIR_UP;

    cx      = pix_x[9:4];
    cy      = pix_y[8:4];
    active  = (pix_x < 10'd640) && (pix_y < 10'd480);
    is_head = (seg_x_q[0] == cx) && (seg_y_q[0] == cy);
    is_food = (food_x_q == cx) && (food_y_q == cy);
    is_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((6'(i) < len_q) && (seg_x_q[i] == cx) && (seg_y_q[i] == cy)) is_body = 1'b1;
    end
    pix_d = 16'h0000;
    if (active) begin
      if (state_q == ST_OVER) pix_d = 16'hF800;
      else if (is_head)       pix_d = 16'hFFE0;
      else if (is_body)       pix_d = 16'h07E0;
      else if (is_food)       pix_d = 16'h001F;
    end

    nh_x = seg_x_q[0];
    nh_y = seg_y_q[0];
    wall = 1'b0;
    case (pend_q)
      DIR_UP:    if (seg_y_q[0] == 5'd0)  wall = 1'b1; else nh_y = seg_y_q[0] - 5'd1;
      DIR_DOWN:  if (seg_y_q[0] == 5'd29) wall = 1'b1; else nh_y = seg_y_q[0] + 5'd1;
      DIR_LEFT:  if (seg_x_q[0] == 6'd0)  wall = 1'b1; else nh_x = seg_x_q[0] - 6'd1;
      default:   if (seg_x_q[0] == 6'd39) wall = 1'b1; else nh_x = seg_x_q[0] + 6'd1;
    endcase
    eat = (nh_x == food_x_q) && (nh_y == food_y_q);
    // The tail vacates its cell on a plain move, but stays put when eating.
    hit_lim  = eat ? len_q : len_q - 6'd1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < hit_lim) && (seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y)) self_hit = 1'b1;
    end
    fx = (lfsr_q[5:0] >= 6'd40) ? lfsr_q[5:0] - 6'd40 : lfsr_q[5:0];
    fy = (lfsr_q[10:6] >= 5'd30) ? lfsr_q[10:6] - 5'd30 : lfsr_q[10:6];

    if (state_q == ST_RUN) begin
      if (move_q) begin
        move_d = 1'b0;
        dir_d  = pend_q;
        if (wall || self_hit) begin
          state_d = ST_OVER;
        end else begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nh_x;
          seg_y_d[0] = nh_y;
          if (eat) begin
            if (len_q < 6'(MAX_LEN)) len_d = len_q + 6'd1;
            if (score_q != 8'hFF)    score_d = score_q + 8'd1;
            food_x_d = fx;
            food_y_d = fy;
          end
        end
      end
      if (key_any && (key_dir != dir_e'(dir_q ^ 2'b01))) pend_d = key_dir;
      if ((pix_x == 10'd639) && (pix_y == 10'd479)) begin
        if (frame_cnt_q == 8'(STEP_FRAMES - 1)) begin
          frame_cnt_d = 8'd0;
          move_d      = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
    end else if (key_any) begin
      state_d     = ST_RUN;
      dir_d       = DIR_RIGHT;
      pend_d      = DIR_RIGHT;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = 6'd0;
        seg_y_d[i] = 5'd0;
      end
      seg_x_d[0]  = 6'd20;
      seg_x_d[1]  = 6'd19;
      seg_x_d[2]  = 6'd18;
      seg_y_d[0]  = 5'd15;
      seg_y_d[1]  = 5'd15;
      seg_y_d[2]  = 5'd15;
      len_d       = 6'd3;
      food_x_d    = 6'd30;
      food_y_d    = 5'd15;
      frame_cnt_d = 8'd0;
      score_d     = 8'd0;
      move_d      = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_RUN;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= 6'd0;
        seg_y_q[i] <= 5'd0;
      end
      seg_x_q[0]  <= 6'd20;
      seg_x_q[1]  <= 6'd19;
      seg_x_q[2]  <= 6'd18;
      seg_y_q[0]  <= 5'd15;
      seg_y_q[1]  <= 5'd15;
      seg_y_q[2]  <= 5'd15;
      len_q       <= 6'd3;
      food_x_q    <= 6'd30;
      food_y_q    <= 5'd15;
      frame_cnt_q <= 8'd0;
      score_q     <= 8'd0;
      move_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      pix_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      food_x_q    <= food_x_d;
      food_y_q    <= food_y_d;
      frame_cnt_q <= frame_cnt_d;
      score_q     <= score_d;
      move_q      <= move_d;
      lfsr_q      <= lfsr_d;
      pix_q       <= pix_d;
    end
  end

  assign pix_data  = pix_q;
  assign game_over = (state_q == ST_OVER);
  assign score     = score_q;

endmodule

// File: tb/tb_snake_pic_gen.sv
// Bench for snake_pic_gen: directed game scenarios with randomized pixel probes,
// checked against a queue-based model of the game rules.
module tb_snake_pic_gen;

  localparam int          STEP    = 2;
  localparam int          MAXL    = 16;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = 10'h3FF;
  logic [9:0]  pix_y = 10'h3FF;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [15:0] pix_data;
  logic        game_over;
  logic [7:0]  score;

  int errors = 0;
  int checks = 0;

  always #20 clk = ~clk;

  snake_pic_gen #(.MAX_LEN(MAXL), .STEP_FRAMES(STEP), .LFSR_SEED(SEED)) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .pix_data(pix_data), .game_over(game_over), .score(score)
  );

  // ---------------- reference model ----------------
  typedef logic [10:0] cell_t;  // {x[5:0], y[4:0]}
  cell_t       snake[$];
  cell_t       m_food;
  int          m_dir, m_pend, m_fc, m_score, m_k, m_dold;
  bit          m_mp, m_over;
  logic [15:0] m_lfsr;
  logic [15:0] exp_pix;

  function automatic cell_t mk(int x, int y);
    mk = {x[5:0], y[4:0]};
  endfunction

  function automatic void m_restart();
    snake = {};
    snake.push_back(mk(20, 15));
    snake.push_back(mk(19, 15));
    snake.push_back(mk(18, 15));
    m_food = mk(30, 15);
    m_dir = 3; m_pend = 3; m_fc = 0; m_score = 0; m_mp = 0; m_over = 0;
  endfunction

  function automatic logic [15:0] m_colour(int x, int y);
    cell_t c;
    if (!(x < 640 && y < 480)) return 16'h0000;
    if (m_over) return 16'hF800;
    c = mk(x / 16, y / 16);
    if (c == snake[0]) return 16'hFFE0;
    for (int i = 1; i < snake.size(); i++) if (c == snake[i]) return 16'h07E0;
    if (c == m_food) return 16'h001F;
    return 16'h0000;
  endfunction

  function automatic void m_move();
    int hx, hy, lim;
    bit eat, hit;
    cell_t nh;
    hx = int'(snake[0][10:5]);
    hy = int'(snake[0][4:0]);
    case (m_pend)
      0: hy = hy - 1;
      1: hy = hy + 1;
      2: hx = hx - 1;
      default: hx = hx + 1;
    endcase
    m_dir = m_pend;
    if (hx < 0 || hx > 39 || hy < 0 || hy > 29) begin
      m_over = 1;
      return;
    end
    nh  = mk(hx, hy);
    eat = (nh == m_food);
    lim = eat ? snake.size() : snake.size() - 1;
    hit = 0;
    for (int i = 0; i < lim; i++) if (snake[i] == nh) hit = 1;
    if (hit) begin
      m_over = 1;
      return;
    end
    snake.push_front(nh);
    if (!eat || snake.size() > MAXL) void'(snake.pop_back());
    if (eat) begin
      if (m_score < 255) m_score++;
      m_food = mk(int'(m_lfsr[5:0]) % 40, int'(m_lfsr[10:6]) % 30);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_restart();
      m_lfsr  = SEED;
      exp_pix = 16'h0000;
    end else begin
      exp_pix = m_colour(int'(pix_x), int'(pix_y));
      m_k = key_up ? 0 : key_down ? 1 : key_left ? 2 : key_right ? 3 : -1;
      if (m_over) begin
        if (m_k >= 0) m_restart();
      end else begin
        m_dold = m_dir;
        if (m_mp) begin
          m_move();
          m_mp = 0;
        end
        if (m_k >= 0 && m_k != (m_dold ^ 1)) m_pend = m_k;
        if (pix_x == 10'd639 && pix_y == 10'd479) begin
          if (m_fc == STEP - 1) begin
            m_fc = 0;
            m_mp = 1;
          end else m_fc++;
        end
      end
      m_lfsr = (m_lfsr >> 1) | 16'((m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
    end
  end

  // ---------------- checks and drivers ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge, then check outputs on the next negedge.
  task automatic tick(input int x, input int y, input logic [3:0] keys);
    pix_x = 10'(x);
    pix_y = 10'(y);
    {key_up, key_down, key_left, key_right} = keys;
    @(posedge clk);
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = 4'b0000;
    chk("pix_data", pix_data, exp_pix);
    chk("game_over", 16'(game_over), 16'(m_over));
    chk("score", 16'(score), 16'(m_score));
  endtask

  task automatic rand_tick(input logic [3:0] keys);
    int x, y, sel;
    cell_t c;
    sel = $urandom_range(0, 3);
    if (sel == 0) begin
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
      if (x >= 640) x = 10'h3FF;
      if (y >= 480) y = 10'h3FF;
    end else begin
      c = (sel == 1) ? m_food : snake[$urandom_range(0, snake.size() - 1)];
      x = int'(c[10:5]) * 16 + $urandom_range(0, 15);
      y = int'(c[4:0]) * 16 + $urandom_range(0, 15);
    end
    tick(x, y, keys);
  endtask

  task automatic frame(input int n, input logic [3:0] keys);
    rand_tick(keys);
    repeat (n) rand_tick(4'b0000);
    tick(639, 479, 4'b0000);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_pix", pix_data, 16'h0000);
    chk("rst_over", 16'(game_over), 16'h0000);
    chk("rst_score", 16'(score), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    tick(320, 240, 4'b0000); chk("layout_head", pix_data, 16'hFFE0);
    tick(336, 240, 4'b0000); chk("layout_empty", pix_data, 16'h0000);
    tick(304, 240, 4'b0000); chk("layout_body", pix_data, 16'h07E0);
    tick(480, 240, 4'b0000); chk("layout_food", pix_data, 16'h001F);
    tick(700, 240, 4'b0000); chk("inactive", pix_data, 16'h0000);

    // Ten moves right reach the food; a reverse key on the way is ignored.
    frame(3, 4'b0000);
    frame(3, 4'b0010);
    repeat (18) frame(3, 4'b0000);
    tick(480, 240, 4'b0000);
    chk("eat_score", 16'(score), 16'd1);
    tick(480, 240, 4'b0000); chk("eat_head", pix_data, 16'hFFE0);

    // Up then left within one step, then left again after the up move.
    tick(100, 100, 4'b1000);
    tick(100, 100, 4'b0010);
    frame(3, 4'b0000);
    frame(3, 4'b0000);
    tick(480, 224, 4'b0000);
    tick(480, 224, 4'b0000); chk("up_head", pix_data, 16'hFFE0);
    tick(100, 100, 4'b0010);
    frame(3, 4'b0000);
    frame(3, 4'b0000);
    tick(464, 224, 4'b0000);
    tick(464, 224, 4'b0000); chk("left_head", pix_data, 16'hFFE0);

    for (int f = 0; f < 40; f++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      frame($urandom_range(1, 4), k);
      if (m_over) tick(100, 100, 4'b0001);
    end

    // Fresh game, then run right into the east wall.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) frame(2, 4'b0000);
    tick(320, 240, 4'b0000);
    chk("wall_over", 16'(game_over), 16'h0001);
    tick(100, 100, 4'b0000); chk("over_red", pix_data, 16'hF800);
    frame(2, 4'b0000);
    frame(2, 4'b0000);
    tick(639, 479, 4'b0000); chk("over_red_corner", pix_data, 16'hF800);

    tick(100, 100, 4'b0100);
    chk("restart_over", 16'(game_over), 16'h0000);
    chk("restart_score", 16'(score), 16'h0000);
    tick(320, 240, 4'b0000); chk("restart_head", pix_data, 16'hFFE0);
    tick(304, 240, 4'b0000); chk("restart_body", pix_data, 16'h07E0);

    // Reset landing on a move cycle.
    repeat (20) frame(3, 4'b0000);
    for (int f = 0; f < 4 && !m_mp; f++) frame(3, 4'b0000);
    chk("move_pending", 16'(m_mp), 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("midmove_pix", pix_data, 16'h0000);
    chk("midmove_over", 16'(game_over), 16'h0000);
    chk("midmove_score", 16'(score), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(320, 240, 4'b0000); chk("rel_head", pix_data, 16'hFFE0);
    tick(304, 240, 4'b0000); chk("rel_body", pix_data, 16'h07E0);
    tick(480, 240, 4'b0000); chk("rel_food", pix_data, 16'h001F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
